// File: rtl/dmem_arbiter_if.sv
// Master-side bus of the data-RAM arbiter: request fields in, read data and ack out.
// Latency: n/a (signal bundle only).
// Backpressure: requester holds req and fields stable until its one-cycle ack.
//
// Signals:
//   req    requester -> arbiter   request, held with fields stable until ack
//   we     requester -> arbiter   write enable (nonzero = write)
//   addr   requester -> arbiter   word address
//   wdata  requester -> arbiter   write data
//   rdata  arbiter -> requester   read data, valid in the ack cycle and held afterwards
//   ack    arbiter -> requester   one-cycle completion pulse
interface dmem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req;
    logic [1:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    // The requester side drives the request fields.
    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    // The arbiter side answers with read data and ack.
    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer serialising m0 (CPU side) and m1 (auxiliary) onto one sync-read RAM.
// Latency: request sampled in IDLE at N, ram_we at N+1, rdata captured end of N+2, ack at N+3.
// Backpressure: a waiting master simply keeps req high; m0 has priority, m1 is forced after STARVE_MAX m0 wins.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m0, m1            master buses (req/we/addr/wdata in, rdata/ack out)
//   ram_addr          RAM word address, latched at grant and held through the transaction
//   ram_data_in       RAM write data, latched at grant
//   ram_we            RAM write enable, nonzero only in the ACCESS cycle
//   ram_data_out      RAM read data, valid one cycle after the address is sampled
//   gnt               one-hot owner (01 = m0, 10 = m1, 00 = idle)
//   busy              a transaction is in progress
module dmem_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_in,
    output logic [1:0]    ram_we,
    input  logic [DW-1:0] ram_data_out,
    output logic [1:0]    gnt,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          grant_m0;
    logic          grant_m1;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    we_q;
    logic [1:0]    gnt_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic [SW-1:0] starve_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_m0 = 1'b0;
        grant_m1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                // m1 wins only when m0 is quiet or m0 has already won
                // STARVE_MAX times in a row while m1 was waiting.
                if (m1.req && ((starve_q == STARVE_LIM) || !m0.req)) begin
                    grant_m1 = 1'b1;
                    state_d  = ACCESS;
                end else if (m0.req) begin
                    grant_m0 = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Latched transaction fields, owner, starvation counter, read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            gnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            starve_q <= '0;
        end else begin
            if (grant_m0) begin
                addr_q  <= m0.addr;
                wdata_q <= m0.wdata;
                we_q    <= m0.we;
                gnt_q   <= 2'b01;
                // Count only the m0 wins that actually kept m1 waiting.
                if (m1.req && (starve_q != STARVE_LIM)) begin
                    starve_q <= starve_q + SW'(1);
                end
            end else if (grant_m1) begin
                addr_q   <= m1.addr;
                wdata_q  <= m1.wdata;
                we_q     <= m1.we;
                gnt_q    <= 2'b10;
                starve_q <= '0;
            end

            // The RAM answers the address sampled at the end of ACCESS,
            // so its output is taken at the end of CAPTURE. Writes capture
            // too; the owner is expected to ignore that value.
            if (state_q == CAPTURE) begin
                if (gnt_q[0]) begin
                    rdata0_q <= ram_data_out;
                end
                if (gnt_q[1]) begin
                    rdata1_q <= ram_data_out;
                end
            end

            // Ownership ends with the ack cycle.
            if (state_q == ACK) begin
                gnt_q <= 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ram_we = 2'b00;
        // Gating with rst lets a reset landing in the ACCESS cycle
        // suppress the write even though the state register has not
        // cleared yet.
        if ((state_q == ACCESS) && !rst) begin
            ram_we = we_q;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_data_in = wdata_q;
    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);

    assign m0.rdata    = rdata0_q;
    assign m1.rdata    = rdata1_q;
    assign m0.ack      = (state_q == ACK) && gnt_q[0];
    assign m1.ack      = (state_q == ACK) && gnt_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic.
// Latency: a transaction occupies four cycles from the sampling cycle to the ack cycle.
// Backpressure: bench masters hold req and fields until their ack, then may change.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [1:0]    ram_we;
    logic [DW-1:0] ram_data_out;
    logic [1:0]    gnt;
    logic          busy;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_if),
        .m1           (m1_if),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_we       (ram_we),
        .ram_data_out (ram_data_out),
        .gnt          (gnt),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM: synchronous read returning the pre-write word.
    logic [DW-1:0] mem [128];
    always @(posedge clk) begin
        if (ram_we != 2'b00) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    // ------------------------------------------------------------------
    // Reference model (transaction timeline)
    // ------------------------------------------------------------------
    logic [DW-1:0] ref_mem [128];
    int            age = 0;        // cycles since the grant; 0 = no transaction
    int            own = 0;        // owning master index
    int            starve = 0;
    int            acked = -1;     // master acked in the cycle just finished
    logic [1:0]    l_we = '0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic [DW-1:0] pend_rd = '0;
    logic [DW-1:0] exp_rd [2];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input int j, input logic r, input logic [1:0] w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (j == 0) begin
            m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model
    // with the inputs sampled at the rising edge.
    task automatic step(input bit do_chk);
        logic m0r;
        logic m1r;
        @(negedge clk);
        if (do_chk) begin
            chk("gnt", 64'(gnt), 64'((age == 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01)));
            chk("busy", 64'(busy), 64'(age != 0));
            chk("ram_we", 64'(ram_we), 64'((age == 1 && !rst) ? l_we : 2'b00));
            chk("m0_ack", 64'(m0_if.ack), 64'(age == 3 && own == 0));
            chk("m1_ack", 64'(m1_if.ack), 64'(age == 3 && own == 1));
            chk("m0_rdata", 64'(m0_if.rdata), 64'(exp_rd[0]));
            chk("m1_rdata", 64'(m1_if.rdata), 64'(exp_rd[1]));
            if (age == 1 || age == 2) chk("ram_addr", 64'(ram_addr), 64'(l_addr));
            if (age == 1) chk("ram_data_in", 64'(ram_data_in), 64'(l_wdata));
        end
        @(posedge clk);
        acked = -1;
        m0r = m0_if.req;
        m1r = m1_if.req;
        if (rst) begin
            age = 0;
            starve = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else if (age == 0) begin
            if (m1r && (starve == STARVE_MAX || !m0r)) begin
                own = 1; starve = 0; age = 1;
                l_we = m1_if.we; l_addr = m1_if.addr; l_wdata = m1_if.wdata;
            end else if (m0r) begin
                own = 0; age = 1;
                if (m1r && starve < STARVE_MAX) starve = starve + 1;
                l_we = m0_if.we; l_addr = m0_if.addr; l_wdata = m0_if.wdata;
            end
        end else if (age == 1) begin
            pend_rd = ref_mem[l_addr];
            if (l_we != 2'b00) ref_mem[l_addr] = l_wdata;
            age = 2;
        end else if (age == 2) begin
            exp_rd[own] = pend_rd;
            age = 3;
        end else begin
            acked = own;
            age = 0;
        end
        #1;
    endtask

    // Random master behaviour honouring the handshake: new request only after
    // ack or while idle; the owner may scramble its inputs once latched.
    task automatic rand_drive();
        logic cur;
        for (int j = 0; j < 2; j++) begin
            cur = (j == 0) ? m0_if.req : m1_if.req;
            if (acked == j || !cur) begin
                drive_m(j, $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                        7'($urandom_range(0, 15)), $urandom);
            end else if (age != 0 && own == j) begin
                drive_m(j, 1'b1, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), $urandom);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[5] = 32'hDEADBEEF;     ref_mem[5] = 32'hDEADBEEF;
        mem[3] = 32'hCAFE0003;     ref_mem[3] = 32'hCAFE0003;

        drive_m(0, 1'b0, 2'b00, '0, '0);
        drive_m(1, 1'b0, 2'b00, '0, '0);

        // Reset
        rst = 1'b1;
        step(0);
        step(0);
        rst = 1'b0;
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_ram_data_in", 64'(ram_data_in), 64'(0));
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) step(1);

        // Single read of word 5 by m0
        drive_m(0, 1'b1, 2'b00, 7'h05, 32'h0);
        step(1);
        chk("rd_addr_n1", 64'(ram_addr), 64'(7'h05));
        step(1);
        step(1);
        chk("rd_ack_n3", 64'(m0_if.ack), 64'(1));
        step(1);
        drive_m(0, 1'b0, 2'b00, 7'h05, 32'h0);
        chk("rd_rdata", 64'(m0_if.rdata), 64'(32'hDEADBEEF));

        // Single write by m1 to 0x7F, then read back by m0
        drive_m(1, 1'b1, 2'b01, 7'h7F, 32'h12345678);
        step(1);
        chk("wr_we_n1", 64'(ram_we), 64'(2'b01));
        chk("wr_data_n1", 64'(ram_data_in), 64'(32'h12345678));
        step(1);
        chk("wr_we_n2", 64'(ram_we), 64'(2'b00));
        step(1);
        step(1);
        drive_m(1, 1'b0, 2'b00, 7'h7F, 32'h0);
        drive_m(0, 1'b1, 2'b00, 7'h7F, 32'h0);
        for (int i = 0; i < 4; i++) step(1);
        drive_m(0, 1'b0, 2'b00, 7'h7F, 32'h0);
        chk("wr_readback", 64'(m0_if.rdata), 64'(32'h12345678));

        // Contention: both masters request continuously for 20 transactions
        drive_m(0, 1'b1, 2'b00, 7'h10, 32'h0);
        drive_m(1, 1'b1, 2'b00, 7'h40, 32'h0);
        for (int t = 0; t < 20; t++) begin
            step(1);
            chk("cont_gnt", 64'(gnt), 64'((t % 5 == 4) ? 2'b10 : 2'b01));
            step(1);
            step(1);
            chk("cont_ack", 64'({m1_if.ack, m0_if.ack}), 64'((t % 5 == 4) ? 2'b10 : 2'b01));
            step(1);
            if (acked == 0) m0_if.addr = m0_if.addr + 7'd1;
            if (acked == 1) m1_if.addr = m1_if.addr + 7'd1;
        end
        drive_m(0, 1'b0, 2'b00, '0, '0);
        drive_m(1, 1'b0, 2'b00, '0, '0);
        step(1);

        // Field stability: owner inputs change after the grant
        drive_m(0, 1'b1, 2'b01, 7'h09, 32'hA5A50009);
        step(1);
        drive_m(0, 1'b1, 2'b11, 7'h2A, 32'hFFFF0000);
        step(1);
        drive_m(0, 1'b1, 2'b10, 7'h33, 32'h0F0F0F0F);
        step(1);
        drive_m(0, 1'b1, 2'b00, 7'h01, 32'h11111111);
        step(1);
        drive_m(0, 1'b1, 2'b00, 7'h09, 32'h0);
        for (int i = 0; i < 4; i++) step(1);
        drive_m(0, 1'b0, 2'b00, 7'h09, 32'h0);
        chk("stab_readback", 64'(m0_if.rdata), 64'(32'hA5A50009));
        chk("stab_mem_2a", 64'(mem[7'h2A]), 64'(ref_mem[7'h2A]));

        // Reset during the ACCESS cycle of an m0 write to word 3
        drive_m(0, 1'b1, 2'b11, 7'h03, 32'h0BAD0BAD);
        step(1);
        rst = 1'b1;
        drive_m(0, 1'b0, 2'b00, 7'h03, 32'h0);
        #1;
        chk("rstacc_we", 64'(ram_we), 64'(0));
        step(1);
        rst = 1'b0;
        chk("rstacc_gnt", 64'(gnt), 64'(0));
        chk("rstacc_busy", 64'(busy), 64'(0));
        chk("rstacc_acks", 64'({m1_if.ack, m0_if.ack}), 64'(0));
        chk("rstacc_rdata0", 64'(m0_if.rdata), 64'(0));
        chk("rstacc_rdata1", 64'(m1_if.rdata), 64'(0));
        chk("rstacc_addr", 64'(ram_addr), 64'(0));
        chk("rstacc_wdata", 64'(ram_data_in), 64'(0));
        chk("rstacc_mem3", 64'(mem[3]), 64'(32'hCAFE0003));
        for (int i = 0; i < 3; i++) step(1);

        // Random traffic against the model
        rand_drive();
        for (int i = 0; i < 400; i++) begin
            step(1);
            rand_drive();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
